// File: rtl/game_ctrl.sv
// Minesweeper game controller: places mines with a free-running LFSR, hands
// the mine map to an adjacency engine, then tracks reveals until win or loss.
module game_ctrl #(
  parameter int         GRID_SIZE     = 5,
  parameter int         TOTAL_SQUARES = GRID_SIZE * GRID_SIZE,
  parameter int         INDEX_WIDTH   = $clog2(TOTAL_SQUARES),
  parameter int         NUM_MINES     = 4,
  parameter logic [7:0] SEED          = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     new_game,
  input  logic                     click_valid,
  input  logic [INDEX_WIDTH-1:0]   click_index,
  output logic                     click_ready,
  output logic [TOTAL_SQUARES-1:0] mine_map,
  output logic                     adj_start,
  input  logic                     adj_done,
  output logic [TOTAL_SQUARES-1:0] revealed,
  output logic                     playing,
  output logic                     win,
  output logic                     lose
);

  localparam int CNT_W = $clog2(TOTAL_SQUARES + 1);
  localparam logic [CNT_W-1:0]     MINE_TARGET = CNT_W'(NUM_MINES);
  localparam logic [CNT_W-1:0]     SAFE_TARGET = CNT_W'(TOTAL_SQUARES - NUM_MINES);
  localparam logic [INDEX_WIDTH:0] TILE_LIMIT  = (INDEX_WIDTH + 1)'(TOTAL_SQUARES);

  typedef enum logic [2:0] {
    IDLE, PLACE, ADJ_START, ADJ_WAIT, PLAY, WIN, LOSE
  } state_t;

  state_t                   state_reg, state_next;
  logic [7:0]               lfsr_reg;
  logic [TOTAL_SQUARES-1:0] mine_map_reg, mine_map_next;
  logic [TOTAL_SQUARES-1:0] revealed_reg, revealed_next;
  logic [CNT_W-1:0]         mine_cnt_reg, mine_cnt_next;
  logic [CNT_W-1:0]         safe_cnt_reg, safe_cnt_next;
  logic [INDEX_WIDTH-1:0]   candidate;
  logic                     candidate_ok;
  logic                     click_ok;
  logic                     begin_game;

  // Candidate tile is the low LFSR bits; out-of-range or duplicate draws are
  // simply retried on the next cycle with the next LFSR value.
  assign candidate    = INDEX_WIDTH'(lfsr_reg);
  assign candidate_ok = ({1'b0, candidate} < TILE_LIMIT) && !mine_map_reg[candidate];
  assign click_ok     = click_valid && ({1'b0, click_index} < TILE_LIMIT) &&
                        !revealed_reg[click_index];
  assign begin_game   = new_game && (state_reg == IDLE || state_reg == PLAY ||
                                     state_reg == WIN  || state_reg == LOSE);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      mine_map_reg <= '0;
      revealed_reg <= '0;
      mine_cnt_reg <= '0;
      safe_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      mine_map_reg <= mine_map_next;
      revealed_reg <= revealed_next;
      mine_cnt_reg <= mine_cnt_next;
      safe_cnt_reg <= safe_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    mine_map_next = mine_map_reg;
    revealed_next = revealed_reg;
    mine_cnt_next = mine_cnt_reg;
    safe_cnt_next = safe_cnt_reg;
    if (begin_game) begin
      // new_game wins over any click presented in the same PLAY cycle.
      state_next    = PLACE;
      mine_map_next = '0;
      revealed_next = '0;
      mine_cnt_next = '0;
      safe_cnt_next = '0;
    end else begin
      case (state_reg)
        PLACE: begin
          if (mine_cnt_reg == MINE_TARGET) begin
            state_next = ADJ_START;
          end else if (candidate_ok) begin
            mine_map_next[candidate] = 1'b1;
            mine_cnt_next            = mine_cnt_reg + 1'b1;
          end
        end
        ADJ_START: state_next = ADJ_WAIT;
        ADJ_WAIT: begin
          if (adj_done) state_next = PLAY;
        end
        PLAY: begin
          if (click_ok) begin
            revealed_next[click_index] = 1'b1;
            if (mine_map_reg[click_index]) begin
              state_next = LOSE;
            end else begin
              safe_cnt_next = safe_cnt_reg + 1'b1;
              if (safe_cnt_next == SAFE_TARGET) state_next = WIN;
            end
          end
        end
        IDLE, WIN, LOSE: state_next = state_reg;
        default: state_next = IDLE;
      endcase
    end
  end

  assign mine_map    = mine_map_reg;
  assign revealed    = revealed_reg;
  assign adj_start   = (state_reg == ADJ_START);
  assign click_ready = (state_reg == PLAY);
  assign playing     = (state_reg == PLAY);
  assign win         = (state_reg == WIN);
  assign lose        = (state_reg == LOSE);

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed game scenarios plus randomized
// play, compared every cycle against a tile-set level model of the rules.
module tb_game_ctrl;

  localparam int TOTAL = 25;
  localparam int IDX_W = 5;
  localparam int NMINE = 4;

  // Model phases (names only; the model reasons about tile sets, not counters)
  localparam int P_IDLE = 0, P_PLACE = 1, P_ADJS = 2, P_ADJW = 3,
                 P_PLAY = 4, P_WIN = 5, P_LOSE = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             new_game = 1'b0;
  logic             click_valid = 1'b0;
  logic [IDX_W-1:0] click_index = '0;
  logic             click_ready;
  logic [TOTAL-1:0] mine_map;
  logic             adj_start;
  logic             adj_done = 1'b0;
  logic [TOTAL-1:0] revealed;
  logic             playing, win, lose;

  int n_checks = 0;
  int n_pass   = 0;

  game_ctrl dut (
    .clk(clk), .rst(rst), .new_game(new_game), .click_valid(click_valid),
    .click_index(click_index), .click_ready(click_ready), .mine_map(mine_map),
    .adj_start(adj_start), .adj_done(adj_done), .revealed(revealed),
    .playing(playing), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit [7:0]     m_lfsr = 8'hA5;
  int           m_phase = P_IDLE;
  bit [TOTAL-1:0] m_mines = '0;
  bit [TOTAL-1:0] m_rev = '0;

  function automatic bit [7:0] lfsr_step(input bit [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always @(posedge clk) begin
    int cand;
    int idx;
    if (rst) begin
      m_phase = P_IDLE; m_lfsr = 8'hA5; m_mines = '0; m_rev = '0;
    end else begin
      cand = int'(m_lfsr) % 32;
      idx  = int'(click_index);
      if (new_game && (m_phase == P_IDLE || m_phase == P_PLAY ||
                       m_phase == P_WIN || m_phase == P_LOSE)) begin
        m_phase = P_PLACE; m_mines = '0; m_rev = '0;
      end else if (m_phase == P_PLACE) begin
        if ($countones(m_mines) == NMINE) m_phase = P_ADJS;
        else if (cand < TOTAL && !m_mines[cand]) m_mines[cand] = 1'b1;
      end else if (m_phase == P_ADJS) begin
        m_phase = P_ADJW;
      end else if (m_phase == P_ADJW) begin
        if (adj_done) m_phase = P_PLAY;
      end else if (m_phase == P_PLAY && click_valid && idx < TOTAL && !m_rev[idx]) begin
        m_rev[idx] = 1'b1;
        if (m_mines[idx]) m_phase = P_LOSE;
        else if ($countones(m_rev & ~m_mines) == TOTAL - NMINE) m_phase = P_WIN;
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  always @(negedge clk) begin
    check("mine_map", mine_map, m_mines);
    check("revealed", revealed, m_rev);
    check("flags {adj_start,click_ready,playing,win,lose}",
          {adj_start, click_ready, playing, win, lose},
          {m_phase == P_ADJS, m_phase == P_PLAY, m_phase == P_PLAY,
           m_phase == P_WIN, m_phase == P_LOSE});
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic click(input int idx);
    click_valid = 1'b1;
    click_index = IDX_W'(idx);
    tick();
    click_valid = 1'b0;
  endtask

  task automatic start_game(input int dly);
    bit found;
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (adj_start) begin found = 1'b1; break; end
      tick();
    end
    check("adj_start_seen", found, 1);
    repeat (dly) tick();
    adj_done = 1'b1;
    tick();
    adj_done = 1'b0;
  endtask

  initial begin
    bit found;
    int pulses, ready_seen, first_mine, nsafe, pick;
    logic [TOTAL-1:0] prev;

    // Reset held two cycles: every output low.
    tick(); tick();
    check("reset outputs", {mine_map, revealed, adj_start, click_ready, playing, win, lose}, 0);
    rst = 1'b0;

    // New game: exactly NMINE mines, single adj_start, no ready while waiting.
    new_game = 1'b1; tick(); new_game = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (adj_start) begin found = 1'b1; break; end
      tick();
    end
    check("adj_start_seen", found, 1);
    check("mine popcount", $countones(mine_map), 4);
    pulses = 1; ready_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (adj_start) pulses++;
      if (click_ready) ready_seen++;
    end
    check("adj_start pulse cycles", pulses, 1);
    check("click_ready during wait", ready_seen, 0);
    adj_done = 1'b1; tick(); adj_done = 1'b0;
    check("playing after adj_done", playing, 1);
    check("click_ready after adj_done", click_ready, 1);

    // Click a mine: revealed bit set and lose next cycle.
    first_mine = 0;
    for (int i = TOTAL - 1; i >= 0; i--) if (m_mines[i]) first_mine = i;
    click(first_mine);
    check("mine tile revealed", revealed[first_mine], 1);
    check("lose after mine", lose, 1);

    // Clear every safe tile, with one repeat and one out-of-range click.
    start_game(3);
    nsafe = 0;
    for (int i = 0; i < TOTAL; i++) begin
      if (!m_mines[i]) begin
        click(i);
        nsafe++;
        check("win progress", win, (nsafe == 21) ? 1 : 0);
        if (nsafe == 1) begin
          prev = revealed;
          click(i);
          check("repeat click no effect", revealed, prev);
          click(25);
          check("index 25 no effect", revealed, prev);
          check("still playing", playing, 1);
        end
      end
    end
    check("safe tiles clicked", nsafe, 21);

    // new_game beats a simultaneous click; reset mid-PLACE returns to IDLE.
    start_game(1);
    pick = 0;
    for (int i = TOTAL - 1; i >= 0; i--) if (!m_mines[i]) pick = i;
    new_game = 1'b1; click_valid = 1'b1; click_index = IDX_W'(pick);
    tick();
    new_game = 1'b0; click_valid = 1'b0;
    check("dropped click revealed", revealed, 0);
    check("placing flags", {adj_start, click_ready, playing, win, lose}, 0);
    tick();
    check("mid-place popcount bound", ($countones(mine_map) <= 2) ? 1 : 0, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mine_map after rst mid-place", mine_map, 0);
    check("flags after rst mid-place", {adj_start, click_ready, playing, win, lose}, 0);

    // Randomized play against the model.
    for (int c = 0; c < 4000; c++) begin
      rst         = ($urandom_range(0, 999) < 3);
      new_game    = ($urandom_range(0, 99) < ((m_phase == P_PLAY) ? 2 : 15));
      click_valid = 1'($urandom_range(0, 1));
      click_index = IDX_W'($urandom_range(0, 31));
      adj_done    = ($urandom_range(0, 99) < 20);
      if (m_phase == P_PLAY && $urandom_range(0, 99) < 70) begin
        for (int t = 0; t < 64; t++) begin
          pick = $urandom_range(0, TOTAL - 1);
          if (!m_mines[pick] && !m_rev[pick]) begin
            click_index = IDX_W'(pick);
            break;
          end
        end
      end
      tick();
    end
    rst = 1'b0; new_game = 1'b0; click_valid = 1'b0; adj_done = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
